imem_loader: RTL

//  Write-side counterpart of the instruction ROM: boot loader that fills the instruction memory.

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory.
// Takes a byte stream made of a 4-byte little-endian length header followed by
// the payload. Payload bytes are packed little-endian into words, and the words
// are written to memory upward from BASE_ADDR. busy_o stays high for the whole
// load, so the CPU is held off until done_o (or err_o) is raised.
module imem_loader #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DATA_W      = 8,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned      DEPTH_BYTES = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [DATA_W-1:0]         s_data_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  output logic                      mem_we_o,
  output logic [WIDTH-1:0]          mem_addr_o,
  output logic [WIDTH-1:0]          mem_wdata_o,
  output logic [WIDTH/DATA_W-1:0]   mem_be_o,
  input  logic                      mem_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int unsigned LANES  = WIDTH / DATA_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_reg;
  logic [1:0]          hdr_cnt_reg;    // header byte index, 0..3
  logic [31:0]         len_reg;        // length header being assembled
  logic [31:0]         remaining_reg;  // payload bytes still to be accepted
  logic [LANE_W-1:0]   lane_reg;       // next byte lane inside the current word
  logic [WIDTH-1:0]    buf_reg;        // word being packed
  logic [LANES-1:0]    be_reg;         // lanes filled so far in the current word
  logic [WIDTH-1:0]    addr_reg;       // byte address of the current word

  logic [31:0]         len_next;
  logic                xfer;

  // Control outputs come from the state register only, never from inputs.
  assign s_ready_o   = (state_reg == S_LEN) || (state_reg == S_DATA);
  assign mem_we_o    = (state_reg == S_WRITE);
  assign busy_o      = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_WRITE);
  assign done_o      = (state_reg == S_DONE);
  assign err_o       = (state_reg == S_ERROR);
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = buf_reg;
  assign mem_be_o    = be_reg;

  assign xfer = s_valid_i && s_ready_o;

  // Header value including the byte currently on the stream.
  always_comb begin
    len_next = len_reg;
    len_next[hdr_cnt_reg*8 +: 8] = s_data_i[7:0];
  end

  // Loader state machine: header capture, byte packing and memory writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      hdr_cnt_reg   <= '0;
      len_reg       <= '0;
      remaining_reg <= '0;
      lane_reg      <= '0;
      buf_reg       <= '0;
      be_reg        <= '0;
      addr_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_reg     <= S_LEN;
            hdr_cnt_reg   <= '0;
            len_reg       <= '0;
            remaining_reg <= '0;
            lane_reg      <= '0;
            buf_reg       <= '0;
            be_reg        <= '0;
            addr_reg      <= BASE_ADDR;
          end
        end

        S_LEN: begin
          if (xfer) begin
            len_reg     <= len_next;
            hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
            if (hdr_cnt_reg == 2'd3) begin
              remaining_reg <= len_next;
              if (len_next == 32'd0) begin
                state_reg <= S_DONE;
              end else if (len_next > DEPTH_BYTES) begin
                state_reg <= S_ERROR;
              end else begin
                state_reg <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            buf_reg[lane_reg*DATA_W +: DATA_W] <= s_data_i;
            be_reg[lane_reg]                   <= 1'b1;
            lane_reg                           <= lane_reg + LANE_W'(1);
            remaining_reg                      <= remaining_reg - 32'd1;
            // Flush on a full word or on the final payload byte.
            if ((lane_reg == LAST_LANE) || (remaining_reg == 32'd1)) begin
              state_reg <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          // Address, data and enables stay put until the memory takes the word.
          if (mem_ready_i) begin
            addr_reg  <= addr_reg + WIDTH'(LANES);
            buf_reg   <= '0;
            be_reg    <= '0;
            lane_reg  <= '0;
            state_reg <= (remaining_reg != 32'd0) ? S_DATA : S_DONE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
